// File: rtl/seg_execute_alu_muldiv_if.sv
// EX-stage operand/control bundle toward the ALU plus its results, stall and HI/LO views.
// master drives the ID/EX side of the bundle; slave is the execute unit.
interface seg_execute_alu_muldiv_if #(
  parameter int NB_DATA   = 32,
  parameter int NB_ALUCTL = 4,
  parameter int NB_OP     = 2,
  parameter int NB_FUNC   = 6,
  parameter int NB_SHAMT  = 5
);
  logic                 i_valid;
  logic [NB_OP-1:0]     i_ALUOp;
  logic [NB_FUNC-1:0]   i_funct;
  logic [NB_SHAMT-1:0]  i_shamt;
  logic [NB_DATA-1:0]   i_data_a;
  logic [NB_DATA-1:0]   i_data_b;
  logic [NB_ALUCTL-1:0] o_ALUctl;
  logic [NB_DATA-1:0]   o_result;
  logic                 o_zero;
  logic                 o_stall;
  logic                 o_done;
  logic [NB_DATA-1:0]   o_hi;
  logic [NB_DATA-1:0]   o_lo;

  modport master (
    output i_valid, i_ALUOp, i_funct, i_shamt, i_data_a, i_data_b,
    input  o_ALUctl, o_result, o_zero, o_stall, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_valid, i_ALUOp, i_funct, i_shamt, i_data_a, i_data_b,
    output o_ALUctl, o_result, o_zero, o_stall, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/seg_execute_alu_muldiv.sv
// Execute stage: ALU decode + single-cycle datapath (0 cycles) and a MULTU/DIVU engine
// taking NB_DATA+1 stall cycles; o_stall holds upstream while busy or on a HI/LO hazard.
module seg_execute_alu_muldiv #(
  parameter int NB_DATA   = 32,
  parameter int NB_ALUCTL = 4,
  parameter int NB_OP     = 2,
  parameter int NB_FUNC   = 6,
  parameter int NB_SHAMT  = 5
) (
  input logic i_clk,
  input logic i_rst_n,
  seg_execute_alu_muldiv_if.slave bus
);

  localparam int NB_CNT = $clog2(NB_DATA) + 1;

  localparam logic [NB_ALUCTL-1:0] CTL_AND   = NB_ALUCTL'(4'b0000);
  localparam logic [NB_ALUCTL-1:0] CTL_OR    = NB_ALUCTL'(4'b0001);
  localparam logic [NB_ALUCTL-1:0] CTL_ADD   = NB_ALUCTL'(4'b0010);
  localparam logic [NB_ALUCTL-1:0] CTL_MULTU = NB_ALUCTL'(4'b0011);
  localparam logic [NB_ALUCTL-1:0] CTL_DIVU  = NB_ALUCTL'(4'b0100);
  localparam logic [NB_ALUCTL-1:0] CTL_SUB   = NB_ALUCTL'(4'b0110);
  localparam logic [NB_ALUCTL-1:0] CTL_SLT   = NB_ALUCTL'(4'b0111);
  localparam logic [NB_ALUCTL-1:0] CTL_SLL   = NB_ALUCTL'(4'b1000);
  localparam logic [NB_ALUCTL-1:0] CTL_SRL   = NB_ALUCTL'(4'b1001);
  localparam logic [NB_ALUCTL-1:0] CTL_SRA   = NB_ALUCTL'(4'b1010);
  localparam logic [NB_ALUCTL-1:0] CTL_NOR   = NB_ALUCTL'(4'b1100);
  localparam logic [NB_ALUCTL-1:0] CTL_XOR   = NB_ALUCTL'(4'b1101);
  localparam logic [NB_ALUCTL-1:0] CTL_MFHI  = NB_ALUCTL'(4'b1110);
  localparam logic [NB_ALUCTL-1:0] CTL_MFLO  = NB_ALUCTL'(4'b1111);

  localparam logic [NB_FUNC-1:0] F_ADD   = NB_FUNC'(6'b100000);
  localparam logic [NB_FUNC-1:0] F_SUB   = NB_FUNC'(6'b100010);
  localparam logic [NB_FUNC-1:0] F_AND   = NB_FUNC'(6'b100100);
  localparam logic [NB_FUNC-1:0] F_OR    = NB_FUNC'(6'b100101);
  localparam logic [NB_FUNC-1:0] F_XOR   = NB_FUNC'(6'b100110);
  localparam logic [NB_FUNC-1:0] F_NOR   = NB_FUNC'(6'b100111);
  localparam logic [NB_FUNC-1:0] F_SLT   = NB_FUNC'(6'b101010);
  localparam logic [NB_FUNC-1:0] F_SLL   = NB_FUNC'(6'b000000);
  localparam logic [NB_FUNC-1:0] F_SRL   = NB_FUNC'(6'b000010);
  localparam logic [NB_FUNC-1:0] F_SRA   = NB_FUNC'(6'b000011);
  localparam logic [NB_FUNC-1:0] F_MFHI  = NB_FUNC'(6'b010000);
  localparam logic [NB_FUNC-1:0] F_MFLO  = NB_FUNC'(6'b010010);
  localparam logic [NB_FUNC-1:0] F_MULTU = NB_FUNC'(6'b011001);
  localparam logic [NB_FUNC-1:0] F_DIVU  = NB_FUNC'(6'b011011);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0]  acc_q, acc_d;   // upper product half / partial remainder
  logic [NB_DATA-1:0]  wrk_q, wrk_d;   // multiplier bits / dividend->quotient bits
  logic [NB_DATA-1:0]  opb_q, opb_d;   // multiplicand / divisor
  logic [NB_DATA-1:0]  hi_q, hi_d;
  logic [NB_DATA-1:0]  lo_q, lo_d;

  logic [NB_ALUCTL-1:0] alu_ctl;
  logic [NB_DATA-1:0]   result;
  logic [NB_DATA:0]     mul_sum;
  logic [NB_DATA:0]     div_shift;
  logic [NB_DATA:0]     div_diff;
  logic                 div_ge;
  logic                 busy;
  logic                 start;
  logic                 is_mfx;

  always_comb begin
    alu_ctl = CTL_ADD;
    if (bus.i_ALUOp == '0) begin
      alu_ctl = CTL_ADD;
    end else if (bus.i_ALUOp[0]) begin
      alu_ctl = CTL_SUB;
    end else begin
      case (bus.i_funct)
        F_ADD:   alu_ctl = CTL_ADD;
        F_SUB:   alu_ctl = CTL_SUB;
        F_AND:   alu_ctl = CTL_AND;
        F_OR:    alu_ctl = CTL_OR;
        F_XOR:   alu_ctl = CTL_XOR;
        F_NOR:   alu_ctl = CTL_NOR;
        F_SLT:   alu_ctl = CTL_SLT;
        F_SLL:   alu_ctl = CTL_SLL;
        F_SRL:   alu_ctl = CTL_SRL;
        F_SRA:   alu_ctl = CTL_SRA;
        F_MFHI:  alu_ctl = CTL_MFHI;
        F_MFLO:  alu_ctl = CTL_MFLO;
        F_MULTU: alu_ctl = CTL_MULTU;
        F_DIVU:  alu_ctl = CTL_DIVU;
        default: alu_ctl = CTL_AND;
      endcase
    end
  end

  always_comb begin
    result = '0;
    case (alu_ctl)
      CTL_ADD:  result = bus.i_data_a + bus.i_data_b;
      CTL_SUB:  result = bus.i_data_a - bus.i_data_b;
      CTL_AND:  result = bus.i_data_a & bus.i_data_b;
      CTL_OR:   result = bus.i_data_a | bus.i_data_b;
      CTL_XOR:  result = bus.i_data_a ^ bus.i_data_b;
      CTL_NOR:  result = ~(bus.i_data_a | bus.i_data_b);
      CTL_SLT:  result = {{(NB_DATA-1){1'b0}}, ($signed(bus.i_data_a) < $signed(bus.i_data_b))};
      CTL_SLL:  result = bus.i_data_b << bus.i_shamt;
      CTL_SRL:  result = bus.i_data_b >> bus.i_shamt;
      CTL_SRA:  result = $unsigned($signed(bus.i_data_b) >>> bus.i_shamt);
      CTL_MFHI: result = hi_q;
      CTL_MFLO: result = lo_q;
      default:  result = '0;
    endcase
  end

  assign busy   = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign start  = (state_q == ST_IDLE) && bus.i_valid &&
                  ((alu_ctl == CTL_MULTU) || (alu_ctl == CTL_DIVU));
  assign is_mfx = (alu_ctl == CTL_MFHI) || (alu_ctl == CTL_MFLO);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    wrk_d   = wrk_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q, wrk_q[NB_DATA-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = ~div_diff[NB_DATA];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          wrk_d   = bus.i_data_a;
          opb_d   = bus.i_data_b;
          cnt_d   = NB_CNT'(NB_DATA);
          state_d = (alu_ctl == CTL_MULTU) ? ST_MUL : ST_DIV;
        end
      end
      ST_MUL: begin
        // Add-then-shift-right: product accumulates in {acc, wrk}.
        acc_d = mul_sum[NB_DATA:1];
        wrk_d = {mul_sum[0], wrk_q[NB_DATA-1:1]};
        cnt_d = cnt_q - NB_CNT'(1);
        if (cnt_d == '0) begin
          state_d = ST_DONE;
          hi_d    = acc_d;
          lo_d    = wrk_d;
        end
      end
      ST_DIV: begin
        if (opb_q == '0) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          hi_d    = wrk_q;
          lo_d    = '1;
        end else begin
          acc_d = div_ge ? div_diff[NB_DATA-1:0] : div_shift[NB_DATA-1:0];
          wrk_d = {wrk_q[NB_DATA-2:0], div_ge};
          cnt_d = cnt_q - NB_CNT'(1);
          if (cnt_d == '0) begin
            state_d = ST_DONE;
            hi_d    = acc_d;
            lo_d    = wrk_d;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      wrk_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wrk_q   <= wrk_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.o_ALUctl = alu_ctl;
  assign bus.o_result = result;
  assign bus.o_zero   = (result == '0);
  assign bus.o_stall  = start || busy || (busy && bus.i_valid && is_mfx);
  assign bus.o_done   = (state_q == ST_DONE);
  assign bus.o_hi     = hi_q;
  assign bus.o_lo     = lo_q;

endmodule

// File: tb/tb_seg_execute_alu_muldiv.sv
// Directed bench for the execute-stage ALU and MULTU/DIVU engine.
module tb_seg_execute_alu_muldiv;

  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02, F_SRA = 6'h03, F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19, F_DIVU = 6'h1B;

  logic clk = 1'b0;
  logic rst_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  seg_execute_alu_muldiv_if bus ();

  seg_execute_alu_muldiv dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [31:0] res;
  } vec_t;

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
    bus.i_valid  = v;
    bus.i_ALUOp  = op;
    bus.i_funct  = f;
    bus.i_shamt  = sh;
    bus.i_data_a = a;
    bus.i_data_b = b;
  endtask

  // Presents an R-type mul/div and counts stall cycles; returns at the first unstalled cycle.
  task automatic issue_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
    @(negedge clk);
    drive(1'b1, 2'b10, f, 5'd0, a, b);
    #1;
    cycles = 0;
    while (bus.o_stall && cycles < 100) begin
      cycles++;
      @(negedge clk);
      #1;
    end
    if (bus.o_stall) cycles = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    vec_cnt++; if (bus.o_hi !== 32'd0) begin err_cnt++; $display("FAIL reset_hi got=%h exp=0", bus.o_hi); end
    vec_cnt++; if (bus.o_lo !== 32'd0) begin err_cnt++; $display("FAIL reset_lo got=%h exp=0", bus.o_lo); end
    vec_cnt++; if (bus.o_done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
    vec_cnt++; if (bus.o_stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall_idle got=%b exp=0", bus.o_stall); end
    drive(1'b1, 2'b10, F_MULTU, 5'd0, 32'd3, 32'd4);
    #1;
    vec_cnt++; if (bus.o_stall !== 1'b1) begin err_cnt++; $display("FAIL reset_stall_multu got=%b exp=1", bus.o_stall); end
    @(negedge clk);
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    #1;
    vec_cnt++; if (bus.o_done !== 1'b0) begin err_cnt++; $display("FAIL reset_release_done got=%b exp=0", bus.o_done); end
  endtask

  task automatic test_rtype;
    vec_t v[15];
    v[0]  = '{2'b00, F_SLT, 5'd0,  32'd7,        32'd8,        4'b0010, 32'd15};
    v[1]  = '{2'b01, F_ADD, 5'd0,  32'd5,        32'd5,        4'b0110, 32'd0};
    v[2]  = '{2'b11, F_AND, 5'd0,  32'd10,       32'd3,        4'b0110, 32'd7};
    v[3]  = '{2'b10, F_ADD, 5'd0,  32'hFFFFFFFF, 32'd1,        4'b0010, 32'd0};
    v[4]  = '{2'b10, F_SUB, 5'd0,  32'd5,        32'd5,        4'b0110, 32'd0};
    v[5]  = '{2'b10, F_AND, 5'd0,  32'h0000F0F0, 32'h0000FF00, 4'b0000, 32'h0000F000};
    v[6]  = '{2'b10, F_OR,  5'd0,  32'h0000F0F0, 32'h0000FF00, 4'b0001, 32'h0000FFF0};
    v[7]  = '{2'b10, F_XOR, 5'd0,  32'h0000F0F0, 32'h0000FF00, 4'b1101, 32'h00000FF0};
    v[8]  = '{2'b10, F_NOR, 5'd0,  32'd0,        32'd0,        4'b1100, 32'hFFFFFFFF};
    v[9]  = '{2'b10, F_SLT, 5'd0,  32'hFFFFFFFF, 32'd1,        4'b0111, 32'd1};
    v[10] = '{2'b10, F_SLT, 5'd0,  32'd1,        32'hFFFFFFFF, 4'b0111, 32'd0};
    v[11] = '{2'b10, F_SLL, 5'd31, 32'd0,        32'd1,        4'b1000, 32'h80000000};
    v[12] = '{2'b10, F_SRL, 5'd4,  32'd0,        32'h80000000, 4'b1001, 32'h08000000};
    v[13] = '{2'b10, F_SRA, 5'd4,  32'd0,        32'h80000000, 4'b1010, 32'hF8000000};
    v[14] = '{2'b10, 6'h3F, 5'd0,  32'h0000FF00, 32'h00000F0F, 4'b0000, 32'h00000F00};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(1'b1, v[i].op, v[i].f, v[i].sh, v[i].a, v[i].b);
      #1;
      vec_cnt++; if (bus.o_ALUctl !== v[i].ctl) begin err_cnt++; $display("FAIL rtype[%0d]_ctl got=%b exp=%b", i, bus.o_ALUctl, v[i].ctl); end
      vec_cnt++; if (bus.o_result !== v[i].res) begin err_cnt++; $display("FAIL rtype[%0d]_result got=%h exp=%h", i, bus.o_result, v[i].res); end
      vec_cnt++; if (bus.o_zero !== (v[i].res == 32'd0)) begin err_cnt++; $display("FAIL rtype[%0d]_zero got=%b exp=%b", i, bus.o_zero, (v[i].res == 32'd0)); end
      vec_cnt++; if (bus.o_stall !== 1'b0) begin err_cnt++; $display("FAIL rtype[%0d]_stall got=%b exp=0", i, bus.o_stall); end
    end
  endtask

  task automatic test_multu;
    int cyc;
    issue_md(F_MULTU, 32'hFFFFFFFF, 32'd2, cyc);
    vec_cnt++; if (cyc !== 33) begin err_cnt++; $display("FAIL multu_stall_cycles got=%0d exp=33", cyc); end
    vec_cnt++; if (bus.o_done !== 1'b1) begin err_cnt++; $display("FAIL multu_done got=%b exp=1", bus.o_done); end
    vec_cnt++; if (bus.o_hi !== 32'h00000001) begin err_cnt++; $display("FAIL multu_hi got=%h exp=00000001", bus.o_hi); end
    vec_cnt++; if (bus.o_lo !== 32'hFFFFFFFE) begin err_cnt++; $display("FAIL multu_lo got=%h exp=fffffffe", bus.o_lo); end
    vec_cnt++; if (bus.o_ALUctl !== 4'b0011) begin err_cnt++; $display("FAIL multu_ctl got=%b exp=0011", bus.o_ALUctl); end
    vec_cnt++; if (bus.o_result !== 32'd0) begin err_cnt++; $display("FAIL multu_result got=%h exp=0", bus.o_result); end
    @(negedge clk);
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'd0, 32'd0);
    #1;
    vec_cnt++; if (bus.o_stall !== 1'b0) begin err_cnt++; $display("FAIL multu_no_restart_stall got=%b exp=0", bus.o_stall); end
    vec_cnt++; if (bus.o_done !== 1'b0) begin err_cnt++; $display("FAIL multu_done_pulse got=%b exp=0", bus.o_done); end
  endtask

  task automatic test_divu;
    int cyc;
    issue_md(F_DIVU, 32'd100, 32'd7, cyc);
    vec_cnt++; if (cyc !== 33) begin err_cnt++; $display("FAIL divu_stall_cycles got=%0d exp=33", cyc); end
    vec_cnt++; if (bus.o_done !== 1'b1) begin err_cnt++; $display("FAIL divu_done got=%b exp=1", bus.o_done); end
    vec_cnt++; if (bus.o_lo !== 32'd14) begin err_cnt++; $display("FAIL divu_lo got=%h exp=0000000e", bus.o_lo); end
    vec_cnt++; if (bus.o_hi !== 32'd2) begin err_cnt++; $display("FAIL divu_hi got=%h exp=00000002", bus.o_hi); end
    @(negedge clk);
    drive(1'b1, 2'b10, F_MFLO, 5'd0, 32'd0, 32'd0);
    #1;
    vec_cnt++; if (bus.o_stall !== 1'b0) begin err_cnt++; $display("FAIL mflo_stall got=%b exp=0", bus.o_stall); end
    vec_cnt++; if (bus.o_result !== 32'd14) begin err_cnt++; $display("FAIL mflo_result got=%h exp=0000000e", bus.o_result); end
    vec_cnt++; if (bus.o_ALUctl !== 4'b1111) begin err_cnt++; $display("FAIL mflo_ctl got=%b exp=1111", bus.o_ALUctl); end
    @(negedge clk);
    drive(1'b1, 2'b10, F_MFHI, 5'd0, 32'd0, 32'd0);
    #1;
    vec_cnt++; if (bus.o_result !== 32'd2) begin err_cnt++; $display("FAIL mfhi_result got=%h exp=00000002", bus.o_result); end
    vec_cnt++; if (bus.o_ALUctl !== 4'b1110) begin err_cnt++; $display("FAIL mfhi_ctl got=%b exp=1110", bus.o_ALUctl); end
    @(negedge clk);
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic test_div_zero;
    int cyc;
    issue_md(F_DIVU, 32'h00001234, 32'd0, cyc);
    vec_cnt++; if (cyc !== 2) begin err_cnt++; $display("FAIL div0_stall_cycles got=%0d exp=2", cyc); end
    vec_cnt++; if (bus.o_done !== 1'b1) begin err_cnt++; $display("FAIL div0_done got=%b exp=1", bus.o_done); end
    vec_cnt++; if (bus.o_lo !== 32'hFFFFFFFF) begin err_cnt++; $display("FAIL div0_lo got=%h exp=ffffffff", bus.o_lo); end
    vec_cnt++; if (bus.o_hi !== 32'h00001234) begin err_cnt++; $display("FAIL div0_hi got=%h exp=00001234", bus.o_hi); end
    @(negedge clk);
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic test_mfhi_hazard;
    int cyc;
    @(negedge clk);
    drive(1'b1, 2'b10, F_MULTU, 5'd0, 32'h00010000, 32'h00030000);
    @(negedge clk);
    drive(1'b1, 2'b10, F_MFHI, 5'd0, 32'd0, 32'd0);
    #1;
    cyc = 0;
    while (bus.o_stall && cyc < 100) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    vec_cnt++; if (cyc !== 32) begin err_cnt++; $display("FAIL hazard_stall_cycles got=%0d exp=32", cyc); end
    vec_cnt++; if (bus.o_done !== 1'b1) begin err_cnt++; $display("FAIL hazard_done got=%b exp=1", bus.o_done); end
    vec_cnt++; if (bus.o_result !== 32'd3) begin err_cnt++; $display("FAIL hazard_mfhi_result got=%h exp=00000003", bus.o_result); end
    vec_cnt++; if (bus.o_lo !== 32'd0) begin err_cnt++; $display("FAIL hazard_lo got=%h exp=0", bus.o_lo); end
    @(negedge clk);
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset_mid;
    int cyc;
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    drive(1'b1, 2'b10, F_MULTU, 5'd0, 32'hFFFFFFFF, 32'd2);
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1;
    vec_cnt++; if (bus.o_stall !== 1'b1) begin err_cnt++; $display("FAIL midrst_busy got=%b exp=1", bus.o_stall); end
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (bus.o_hi !== 32'd0) begin err_cnt++; $display("FAIL midrst_hi got=%h exp=0", bus.o_hi); end
    vec_cnt++; if (bus.o_lo !== 32'd0) begin err_cnt++; $display("FAIL midrst_lo got=%h exp=0", bus.o_lo); end
    vec_cnt++; if (bus.o_stall !== 1'b1) begin err_cnt++; $display("FAIL midrst_stall_start got=%b exp=1", bus.o_stall); end
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'd0, 32'd0);
    #1;
    vec_cnt++; if (bus.o_stall !== 1'b0) begin err_cnt++; $display("FAIL midrst_stall_idle got=%b exp=0", bus.o_stall); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (bus.o_done) done_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (bus.o_done) done_seen++;
    end
    vec_cnt++; if (done_seen !== 0) begin err_cnt++; $display("FAIL midrst_done_pulses got=%0d exp=0", done_seen); end
    issue_md(F_MULTU, 32'd3, 32'd4, cyc);
    vec_cnt++; if (cyc !== 33) begin err_cnt++; $display("FAIL postrst_stall_cycles got=%0d exp=33", cyc); end
    vec_cnt++; if (bus.o_lo !== 32'd12) begin err_cnt++; $display("FAIL postrst_lo got=%h exp=0000000c", bus.o_lo); end
    vec_cnt++; if (bus.o_hi !== 32'd0) begin err_cnt++; $display("FAIL postrst_hi got=%h exp=0", bus.o_hi); end
    @(negedge clk);
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_multu;
    test_divu;
    test_div_zero;
    test_mfhi_hazard;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test sequence");
    $fatal(1);
  end

endmodule

// File: doc/seg_execute_alu_muldiv.md
Name: seg_execute_alu_muldiv

Overview:
Parametrised execute-stage ALU control plus datapath for the MIPS pipeline.
- Decodes i_ALUOp/i_funct to a 4-bit ALU control word and computes single-cycle results (arith/logic/shift/SLT).
- Adds a multi-cycle unsigned multiply/divide engine with HI/LO registers and a stall handshake to hold the pipeline.
- Sits between the ID/EX and EX/MEM registers.

Parameters:
NB_DATA, 32, operand/result width (even, >=8)
NB_ALUCTL, 4, ALU control word width
NB_OP, 2, ALUOp width
NB_FUNC, 6, funct field width
NB_SHAMT, 5, shift amount width (clog2(NB_DATA))

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  instruction in EX is valid
i_ALUOp  in  NB_OP  ALUOp from control unit
i_funct  in  NB_FUNC  R-type funct field
i_shamt  in  NB_SHAMT  shift amount
i_data_a  in  NB_DATA  operand A (rs)
i_data_b  in  NB_DATA  operand B (rt/imm)
o_ALUctl  out  NB_ALUCTL  decoded control word
o_result  out  NB_DATA  combinational result
o_zero  out  1  o_result == 0
o_stall  out  1  hold IF/ID/EX, bubble EX/MEM
o_done  out  1  one-cycle pulse when HI/LO updated
o_hi  out  NB_DATA  HI register
o_lo  out  NB_DATA  LO register

Behaviour:
- Decode is combinational.
  - ALUOp 00 -> 0010 (add); ?1 -> 0110 (sub); 1? -> R-type on the full funct, exact match:
  - 100000 ADD 0010; 100010 SUB 0110; 100100 AND 0000; 100101 OR 0001; 100110 XOR 1101; 100111 NOR 1100; 101010 SLT 0111.
  - 000000 SLL 1000; 000010 SRL 1001; 000011 SRA 1010; 010000 MFHI 1110; 010010 MFLO 1111; 011001 MULTU 0011; 011011 DIVU 0100.
  - Any other funct -> 0000.
- Single-cycle ops: add/sub wrap modulo 2^NB_DATA, no overflow trap.
  - SLT is signed; result is 1 or 0, zero-extended.
  - Shifts shift i_data_b by i_shamt; SRA sign-fills.
  - MFHI/MFLO return o_hi/o_lo.
  - MULTU/DIVU drive o_result = 0.
- FSM states IDLE, MUL, DIV, DONE; counter of clog2(NB_DATA)+1 bits.
  - IDLE: i_valid & MULTU -> MUL; i_valid & DIVU -> DIV. Operands are latched and the counter loaded with NB_DATA.
  - MUL: shift-add, one bit per cycle; DIV: restoring, one quotient bit per cycle. Leave for DONE when the counter hits 0.
  - On entry to DONE: LO = product[NB_DATA-1:0] or quotient; HI = product upper half or remainder.
  - DONE lasts one cycle with o_done = 1, then -> IDLE unconditionally. The instruction still presented in the DONE cycle does not restart the FSM.
- o_stall is combinational.
  - High in the IDLE start cycle when i_valid & MULTU/DIVU.
  - High throughout MUL/DIV.
  - High when i_valid & MFHI/MFLO while in MUL/DIV (HI/LO hazard).
  - Low in DONE. Total stall for MULTU/DIVU is NB_DATA+1 cycles; upstream holds inputs stable while stalled.
- Divide by zero (latched divisor == 0): DIV goes to DONE after 1 cycle with LO = all ones, HI = dividend.
- A new MULTU/DIVU during MUL/DIV cannot occur (the pipeline is stalled). Inputs are ignored until IDLE.
- i_valid = 0: o_stall = 0 except while in MUL/DIV. Decode and o_result still evaluate.
- Reset, at any time including mid-operation:
  - State -> IDLE, counter 0, HI = LO = 0, o_done = 0.
  - o_stall = 0 unless i_valid & MULTU/DIVU.
  - The in-flight operation is discarded.

Test Plan:
- R-type sweep with NB_DATA=32:
  - SLT a=0xFFFFFFFF, b=1 -> o_result=1, o_ALUctl=0111.
  - SRA b=0x80000000, shamt=4 -> 0xF8000000.
  - SUB 5-5 -> o_zero=1.
  - Unknown funct 111111 -> o_ALUctl=0000.
- MULTU a=0xFFFFFFFF, b=2 -> o_stall high for 33 cycles, o_done pulse, then HI=0x00000001, LO=0xFFFFFFFE. The DONE-cycle re-presentation does not restart the FSM.
- DIVU a=100, b=7 -> after 33 stall cycles LO=14, HI=2. A following MFLO returns 14 with no stall.
- DIVU a=0x1234, b=0 -> stall 2 cycles, LO=0xFFFFFFFF, HI=0x1234.
- MFHI issued while MUL is busy -> o_stall held until DONE; MFHI then returns the new HI.
- Assert i_rst_n=0 at cycle 10 of a MULTU -> immediate IDLE, HI=LO=0, o_done never pulses. After release, MULTU 3*4 -> LO=12.
